// File: rtl/exec_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctl_pkg
// Description : Shared types for the execute-stage controller. Holds the
//               controller state enum, the next-PC mux select encodings and
//               a helper that derives the select from captured control flags.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_ctl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] PC_INC = 2'b00;  // sequential fetch
    localparam logic [1:0] PC_JB  = 2'b01;  // immediate jump / taken branch target
    localparam logic [1:0] PC_ALU = 2'b10;  // register target from the ALU

    // A register-target jump outranks every other transfer kind.
    function automatic logic [1:0] sel_pc(input logic jr, input logic jump,
                                          input logic branch, input logic taken);
        if (jr)
            return PC_ALU;
        else if (jump || (branch && taken))
            return PC_JB;
        else
            return PC_INC;
    endfunction

endpackage : exec_ctl_pkg
`default_nettype wire

// File: rtl/exec_ctl_squash_cnt.sv
`default_nettype none
// ============================================================================
// Module      : squash_cnt
// Description : 3-bit loadable down-counter that times the squash window
//               after a redirect. Saturates at zero; done is high while the
//               count sits at 1, i.e. during the final squash cycle.
// Ports       : clk, rst_n        - clock, async active-low reset
//               load, load_val    - load the counter (has priority over dec)
//               dec               - decrement by one this cycle
//               done              - last cycle of the window
// Revision    : 1.0 - initial release
// ============================================================================
module squash_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [2:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= 3'd0;
        else if (load)
            r_count <= load_val;
        else if (dec && (r_count != 3'd0))
            r_count <= r_count - 3'd1;
    end

    assign done = (r_count == 3'd1);

endmodule : squash_cnt
`default_nettype wire

// File: rtl/exec_ctl.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctl
// Description : Execute-stage pipeline controller. Holds one instruction's
//               control flags, hands it to the memory stage, steers the
//               next-PC mux, raises a one-cycle redirect on control transfers,
//               squashes younger fetches for FLUSH_CYCLES cycles afterwards,
//               and parks the core in HALT until reset.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               in_valid/in_ready             - decode handshake
//               in_jump/in_jr/in_branch/
//               in_taken/in_halt              - decoded control flags
//               out_valid/out_ready           - memory-stage handshake
//               ex_en                         - execute register load enable
//               pc_sel                        - next-PC mux select
//               redirect                      - fetch loads selected PC
//               flush                         - younger fetches squashed
//               halted                        - core halted
// Revision    : 1.0 - initial release
// ============================================================================
module exec_ctl
    import exec_ctl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2      // legal range 1..7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_jump,
    input  logic       in_jr,
    input  logic       in_branch,
    input  logic       in_taken,
    input  logic       in_halt,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ex_en,
    output logic [1:0] pc_sel,
    output logic       redirect,
    output logic       flush,
    output logic       halted
);

    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES);

    state_t r_state;
    logic   r_jump;
    logic   r_jr;
    logic   r_branch;
    logic   r_taken;
    logic   r_halt;

    logic   w_xfer;
    logic   w_handoff;
    logic   w_accept;
    logic   w_cnt_done;

    // Status outputs are pure decodes of the state register.
    assign out_valid = (r_state == ST_FULL);
    assign flush     = (r_state == ST_FLUSH);
    assign halted    = (r_state == ST_HALT);

    assign w_xfer    = r_jr | r_jump | (r_branch & r_taken);
    assign w_handoff = out_valid & out_ready;

    // Nothing may slip in behind a transfer or a HALT: the instruction after
    // it is on the wrong path or must never execute.
    always_comb begin
        in_ready = 1'b1;
        case (r_state)
            ST_EMPTY: in_ready = 1'b1;
            ST_FULL:  in_ready = out_ready & ~w_xfer & ~r_halt;
            ST_FLUSH: in_ready = 1'b1;   // swallow and discard wrong-path fetches
            ST_HALT:  in_ready = 1'b0;
            default:  in_ready = 1'b1;
        endcase
    end

    assign w_accept = in_valid & in_ready;
    // Instructions accepted while flushing are dropped, never loaded.
    assign ex_en    = w_accept & ~flush;

    // HALT outranks a transfer flag captured with it.
    assign redirect = w_handoff & ~r_halt & w_xfer;
    assign pc_sel   = out_valid ? sel_pc(r_jr, r_jump, r_branch, r_taken) : PC_INC;

    squash_cnt u_squash_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (redirect),
        .load_val (c_flush_load),
        .dec      (flush),
        .done     (w_cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_jump   <= 1'b0;
            r_jr     <= 1'b0;
            r_branch <= 1'b0;
            r_taken  <= 1'b0;
            r_halt   <= 1'b0;
        end else begin
            if (ex_en) begin
                r_jump   <= in_jump;
                r_jr     <= in_jr;
                r_branch <= in_branch;
                r_taken  <= in_taken;
                r_halt   <= in_halt;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept)
                        r_state <= ST_FULL;
                end
                ST_FULL: begin
                    if (w_handoff) begin
                        if (r_halt)
                            r_state <= ST_HALT;
                        else if (w_xfer)
                            r_state <= ST_FLUSH;
                        else if (w_accept)
                            r_state <= ST_FULL;
                        else
                            r_state <= ST_EMPTY;
                    end
                end
                ST_FLUSH: begin
                    if (w_cnt_done)
                        r_state <= ST_EMPTY;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule : exec_ctl
`default_nettype wire

// File: doc/exec_ctl.md
EXEC_CTL -- requirements
Module: exec_ctl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles younger fetches are squashed after a redirect; legal range 1..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  decode presents an instruction.
REQ-005 in_ready  output  1  execute stage accepts the instruction this cycle.
REQ-006 in_jump  input  1  instruction is an immediate-target jump.
REQ-007 in_jr  input  1  instruction is a register-target jump (JR/JALR).
REQ-008 in_branch  input  1  instruction is a conditional branch.
REQ-009 in_taken  input  1  branch condition true (from ALU Zero/sign logic).
REQ-010 in_halt  input  1  instruction is HALT.
REQ-011 out_valid  output  1  stage register holds an instruction for memory stage.
REQ-012 out_ready  input  1  memory stage accepts this cycle.
REQ-013 ex_en  output  1  load enable for the execute pipeline register.
REQ-014 pc_sel  output  2  next-PC mux select: 00 inc_pc, 01 jump/branch target, 10 ALU result.
REQ-015 redirect  output  1  one-cycle pulse: fetch must load the selected PC.
REQ-016 flush  output  1  younger instructions are being squashed.
REQ-017 halted  output  1  processor halted.

Function
REQ-018 States: EMPTY, FULL, FLUSH, HALT; captured flags jump/jr/branch/taken/halt held in registers loaded when ex_en=1.
REQ-019 Handoff = out_valid & out_ready; accept = in_valid & in_ready; ex_en = accept.
REQ-020 Captured transfer xfer = jr | jump | (branch & taken).
REQ-021 EMPTY: in_ready=1, out_valid=0; accept -> FULL.
REQ-022 FULL: out_valid=1; in_ready = out_ready & ~xfer & ~halt (no younger instruction enters behind a transfer or HALT).
REQ-023 FULL, no handoff: hold state and flags, ex_en=0.
REQ-024 FULL, handoff, captured halt: -> HALT (halt wins over xfer).
REQ-025 FULL, handoff, xfer: redirect=1 that cycle, -> FLUSH, counter loaded with FLUSH_CYCLES.
REQ-026 FULL, handoff, neither: accept -> FULL with new flags, else -> EMPTY.
REQ-027 pc_sel combinational from captured flags while out_valid: jr -> 10, else jump|(branch&taken) -> 01, else 00; 00 when out_valid=0.
REQ-028 FLUSH: flush=1, in_ready=1, out_valid=0, ex_en=0 (accepted instructions discarded); counter decrements each cycle; at counter==1 next state EMPTY.
REQ-029 HALT: in_ready=0, out_valid=0, halted=1; exit only by reset.
REQ-030 redirect never asserted in two consecutive cycles.

Reset
REQ-031 rst_n low asynchronously forces EMPTY, counter 0, all flags 0; outputs: in_ready=1, out_valid=0, ex_en=0, pc_sel=00, redirect=0, flush=0, halted=0.
REQ-032 Reset during FLUSH or HALT returns to EMPTY with no redirect pulse on release.

Structure
REQ-033 Package exec_ctl_pkg holds the state enum and pc_sel encodings (PC_INC, PC_JB, PC_ALU).
REQ-034 One sub-module squash_cnt: 3-bit loadable down-counter with done flag.

Verification
REQ-035 Reset mid-FLUSH (cycle 1 of 2) -> next cycle EMPTY, flush=0, redirect=0, in_ready=1.
REQ-036 Back-to-back ALU ops, out_ready=1 -> one handoff per cycle, pc_sel=00, redirect never 1.
REQ-037 Branch taken=1, FLUSH_CYCLES=2 -> redirect pulse at handoff, pc_sel=01, flush=1 for exactly 2 cycles, instructions offered then never appear on out_valid.
REQ-038 JR held with out_ready=0 for 3 cycles -> pc_sel=10 stable, in_ready=0, no redirect until handoff.
REQ-039 Branch taken=0 -> pc_sel=00, no redirect, next instruction accepted same cycle.
REQ-040 HALT with jump flag also set -> HALT state, halted=1, redirect=0, in_ready=0 indefinitely.
